// File: rtl/count_event_pkg.sv
// count_event_pkg
//   Shared definitions for the counter event logger: flag bit positions,
//   field widths, the event record layout, saturation limits and
//   saturating-increment helpers.
package count_event_pkg;

    localparam int unsigned FLAG_CARRY  = 0;
    localparam int unsigned FLAG_BORROW = 1;
    localparam int unsigned FLAG_PERR   = 2;

    localparam int unsigned FLAG_W   = 3;
    localparam int unsigned COUNT_W  = 9;
    localparam int unsigned TS_W_DEF = 16;

    localparam logic [15:0] TOTAL_SAT = '1;
    localparam logic [7:0]  DROP_SAT  = '1;

    // Record layout at the default timestamp width; the top level packs the
    // same field order into a flat vector so TS_W can be overridden.
    typedef struct packed {
        logic [FLAG_W-1:0]   flags;
        logic [COUNT_W-1:0]  count;
        logic [TS_W_DEF-1:0] time_stamp;
    } count_event_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == TOTAL_SAT) ? v : v + 16'd1;
    endfunction

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == DROP_SAT) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/count_event_fifo.sv
// count_event_fifo
//   Generic synchronous FIFO, registered level, no write-to-read bypass.
//   Ports:
//     clock, reset      - rising-edge clock, synchronous active-high reset
//     push, din         - write request and data
//     push_accepted     - write request taken this cycle
//     pop               - read request (ignored when empty)
//     dout              - head entry, zero when empty
//     full, empty       - occupancy flags
//     level             - occupancy 0..DEPTH
module count_event_fifo #(
    parameter int unsigned WIDTH = 28,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    output logic                     push_accepted,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             pop_ok;
    logic             push_ok;

    always_comb begin
        full    = (level_q == LVL_W'(DEPTH));
        empty   = (level_q == '0);
        pop_ok  = pop && !empty;
        // A full FIFO still takes a write when the head leaves the same cycle.
        push_ok = push && (!full || pop_ok);
        push_accepted = push_ok;

        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;

        if (push_ok) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        // Storage is not reset, so mask the head while empty.
        dout  = empty ? '0 : mem_q[rd_ptr_q];
        level = level_q;
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

endmodule

// File: rtl/count_event_logger.sv
// count_event_logger
//   Monitors a 9-bit up/down counter, checks parity, and queues carry /
//   borrow / parity-error events as timestamped records for a valid/ready
//   consumer. Keeps saturating totals and sticky error flags.
//   Ports:
//     clock, reset                 - clock, synchronous active-high reset
//     mon_en                       - enables event detection
//     clear                        - zeroes totals and sticky flags
//     count_in, carry_in,
//     borrow_in, parity_in         - counter outputs being monitored
//     evt_valid, evt_ready         - record handshake
//     evt_flags, evt_count,
//     evt_time                     - head record {perr,borrow,carry}, count, time
//     carry_total, borrow_total,
//     drop_total                   - saturating event totals
//     parity_err_sticky,
//     overflow_sticky              - sticky error flags
//     fifo_level                   - records queued
module count_event_logger
    import count_event_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   mon_en,
    input  logic                   clear,
    input  logic [8:0]             count_in,
    input  logic                   carry_in,
    input  logic                   borrow_in,
    input  logic                   parity_in,
    output logic                   evt_valid,
    input  logic                   evt_ready,
    output logic [2:0]             evt_flags,
    output logic [8:0]             evt_count,
    output logic [TS_W-1:0]        evt_time,
    output logic [15:0]            carry_total,
    output logic [15:0]            borrow_total,
    output logic [7:0]             drop_total,
    output logic                   parity_err_sticky,
    output logic                   overflow_sticky,
    output logic [$clog2(DEPTH):0] fifo_level
);
    localparam int unsigned REC_W = FLAG_W + COUNT_W + TS_W;

    logic [TS_W-1:0]   ts_q, ts_d;
    logic [15:0]       carry_total_q, carry_total_d;
    logic [15:0]       borrow_total_q, borrow_total_d;
    logic [7:0]        drop_total_q, drop_total_d;
    logic              perr_sticky_q, perr_sticky_d;
    logic              ovf_sticky_q, ovf_sticky_d;

    logic              perr;
    logic [FLAG_W-1:0] flags;
    logic              push;
    logic              push_accepted;
    logic              pop;
    logic              drop;
    logic              fifo_empty;
    logic              fifo_full;
    logic [REC_W-1:0]  rec_in;
    logic [REC_W-1:0]  rec_out;

    always_comb begin
        perr  = ((^count_in) != parity_in);
        flags = '0;
        if (mon_en) begin
            flags[FLAG_CARRY]  = carry_in;
            flags[FLAG_BORROW] = borrow_in;
            flags[FLAG_PERR]   = perr;
        end
        push   = (flags != '0);
        rec_in = {flags, count_in, ts_q};
        pop    = !fifo_empty && evt_ready;
        drop   = push && !push_accepted;

        ts_d = ts_q + 1'b1;

        carry_total_d  = carry_total_q;
        borrow_total_d = borrow_total_q;
        drop_total_d   = drop_total_q;
        perr_sticky_d  = perr_sticky_q;
        ovf_sticky_d   = ovf_sticky_q;

        // clear overrides any coincident increment or set; the record itself
        // still goes to the FIFO.
        if (clear) begin
            carry_total_d  = '0;
            borrow_total_d = '0;
            drop_total_d   = '0;
            perr_sticky_d  = 1'b0;
            ovf_sticky_d   = 1'b0;
        end else begin
            if (flags[FLAG_CARRY])  carry_total_d  = sat_inc16(carry_total_q);
            if (flags[FLAG_BORROW]) borrow_total_d = sat_inc16(borrow_total_q);
            if (flags[FLAG_PERR])   perr_sticky_d  = 1'b1;
            if (drop) begin
                drop_total_d = sat_inc8(drop_total_q);
                ovf_sticky_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ts_q           <= '0;
            carry_total_q  <= '0;
            borrow_total_q <= '0;
            drop_total_q   <= '0;
            perr_sticky_q  <= 1'b0;
            ovf_sticky_q   <= 1'b0;
        end else begin
            ts_q           <= ts_d;
            carry_total_q  <= carry_total_d;
            borrow_total_q <= borrow_total_d;
            drop_total_q   <= drop_total_d;
            perr_sticky_q  <= perr_sticky_d;
            ovf_sticky_q   <= ovf_sticky_d;
        end
    end

    count_event_fifo #(
        .WIDTH (REC_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock         (clock),
        .reset         (reset),
        .push          (push),
        .din           (rec_in),
        .push_accepted (push_accepted),
        .pop           (pop),
        .dout          (rec_out),
        .full          (fifo_full),
        .empty         (fifo_empty),
        .level         (fifo_level)
    );

    always_comb begin
        evt_valid = !fifo_empty;
        {evt_flags, evt_count, evt_time} = rec_out;
        carry_total       = carry_total_q;
        borrow_total      = borrow_total_q;
        drop_total        = drop_total_q;
        parity_err_sticky = perr_sticky_q;
        overflow_sticky   = ovf_sticky_q;
    end

endmodule

// File: tb/tb_count_event_logger.sv
// tb_count_event_logger
//   Directed bench for count_event_logger with DEPTH=8, TS_W=16.
module tb_count_event_logger;
    logic        clock;
    logic        reset;
    logic        mon_en;
    logic        clear;
    logic [8:0]  count_in;
    logic        carry_in;
    logic        borrow_in;
    logic        parity_in;
    logic        evt_valid;
    logic        evt_ready;
    logic [2:0]  evt_flags;
    logic [8:0]  evt_count;
    logic [15:0] evt_time;
    logic [15:0] carry_total;
    logic [15:0] borrow_total;
    logic [7:0]  drop_total;
    logic        parity_err_sticky;
    logic        overflow_sticky;
    logic [3:0]  fifo_level;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    logic [15:0] ts_model = '0;
    logic [15:0] t_s;
    logic [15:0] ts_arr [10];

    count_event_logger #(
        .DEPTH (8),
        .TS_W  (16)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .mon_en            (mon_en),
        .clear             (clear),
        .count_in          (count_in),
        .carry_in          (carry_in),
        .borrow_in         (borrow_in),
        .parity_in         (parity_in),
        .evt_valid         (evt_valid),
        .evt_ready         (evt_ready),
        .evt_flags         (evt_flags),
        .evt_count         (evt_count),
        .evt_time          (evt_time),
        .carry_total       (carry_total),
        .borrow_total      (borrow_total),
        .drop_total        (drop_total),
        .parity_err_sticky (parity_err_sticky),
        .overflow_sticky   (overflow_sticky),
        .fifo_level        (fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge; outputs are sampled 1 ns later. ts_model tracks the
    // timestamp the DUT will present for the next sampled edge.
    task automatic tick();
        @(posedge clock);
        #1;
        ts_model = reset ? 16'd0 : ts_model + 16'd1;
    endtask

    task automatic drive(input logic [8:0] cnt, input logic car, input logic bor, input logic bad_par);
        count_in  = cnt;
        carry_in  = car;
        borrow_in = bor;
        parity_in = (^cnt) ^ bad_par;
    endtask

    initial begin
        reset = 1'b1; mon_en = 1'b1; clear = 1'b0; evt_ready = 1'b0;
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // Reset state
        check("rst_valid", evt_valid, 0);
        check("rst_flags", evt_flags, 0);
        check("rst_count", evt_count, 0);
        check("rst_time", evt_time, 0);
        check("rst_level", fifo_level, 0);
        check("rst_carry_total", carry_total, 0);
        check("rst_drop_total", drop_total, 0);
        check("rst_sticky", {parity_err_sticky, overflow_sticky}, 0);
        reset = 1'b0;

        // Carry record
        evt_ready = 1'b1;
        drive(9'h1FE, 1'b1, 1'b0, 1'b0);
        t_s = ts_model;
        tick();
        check("carry_valid", evt_valid, 1);
        check("carry_flags", evt_flags, 3'b001);
        check("carry_count", evt_count, 9'h1FE);
        check("carry_time", evt_time, t_s);
        check("carry_total1", carry_total, 1);
        check("carry_level", fifo_level, 1);
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        tick();
        check("carry_popped", evt_valid, 0);

        // Parity error, then correct parity produces nothing
        drive(9'h003, 1'b0, 1'b0, 1'b1);
        t_s = ts_model;
        tick();
        check("perr_flags", evt_flags, 3'b100);
        check("perr_count", evt_count, 9'h003);
        check("perr_time", evt_time, t_s);
        check("perr_sticky", parity_err_sticky, 1);
        drive(9'h003, 1'b0, 1'b0, 1'b0);
        tick();
        check("perr_norecord", evt_valid, 0);
        check("perr_norecord_lvl", fifo_level, 0);

        // Detection disabled, timestamp keeps running
        mon_en = 1'b0;
        drive(9'h005, 1'b1, 1'b1, 1'b1);
        tick(); tick();
        check("mon_off_valid", evt_valid, 0);
        check("mon_off_carry", carry_total, 1);
        mon_en = 1'b1;
        drive(9'h010, 1'b0, 1'b1, 1'b0);
        t_s = ts_model;
        tick();
        check("mon_on_time", evt_time, t_s);
        check("mon_on_flags", evt_flags, 3'b010);
        check("mon_on_borrow", borrow_total, 1);
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        tick();

        // Clear, then carry and borrow together
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_carry", carry_total, 0);
        check("clr_borrow", borrow_total, 0);
        check("clr_perr", parity_err_sticky, 0);
        drive(9'h100, 1'b1, 1'b1, 1'b0);
        tick();
        check("cb_flags", evt_flags, 3'b011);
        check("cb_carry", carry_total, 1);
        check("cb_borrow", borrow_total, 1);
        check("cb_level", fifo_level, 1);
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        tick();

        // Overflow: 10 carries into an 8-deep FIFO with no consumer
        evt_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(9'(i), 1'b1, 1'b0, 1'b0);
            ts_arr[i] = ts_model;
            tick();
        end
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        check("ovf_level", fifo_level, 8);
        check("ovf_drop", drop_total, 2);
        check("ovf_sticky", overflow_sticky, 1);
        check("ovf_carry", carry_total, 11);
        tick();
        check("ovf_hold_time", evt_time, ts_arr[0]);
        check("ovf_hold_count", evt_count, 0);
        evt_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("drain_valid", evt_valid, 1);
            check("drain_count", evt_count, i);
            check("drain_time", evt_time, ts_arr[i]);
            tick();
        end
        check("drain_empty", evt_valid, 0);
        check("drain_level", fifo_level, 0);

        // Full FIFO with a simultaneous pop and push
        evt_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(9'h040 + 9'(i), 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("full_level", fifo_level, 8);
        check("full_drop", drop_total, 2);
        evt_ready = 1'b1;
        drive(9'h0AA, 1'b1, 1'b0, 1'b0);
        tick();
        check("fullpop_level", fifo_level, 8);
        check("fullpop_drop", drop_total, 2);
        check("fullpop_head", evt_count, 9'h041);
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) begin
            check("fullpop_drain", evt_count, (j < 7) ? 9'h041 + 9'(j) : 9'h0AA);
            tick();
        end
        check("fullpop_empty", fifo_level, 0);

        // Continuous stream with ready held high, up to carry saturation
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 65534; k++) begin
            drive(9'h1FE, 1'b1, 1'b0, 1'b0);
            tick();
        end
        check("stream_carry", carry_total, 16'hFFFE);
        check("stream_drop", drop_total, 0);
        check("stream_level", fifo_level, 1);
        for (int k = 0; k < 3; k++) tick();
        check("sat_carry", carry_total, 16'hFFFF);
        check("sat_level", fifo_level, 1);

        // Drop total saturation
        evt_ready = 1'b0;
        for (int k = 0; k < 268; k++) tick();
        check("sat_drop", drop_total, 8'hFF);
        check("sat_ovf", overflow_sticky, 1);
        check("sat_drop_level", fifo_level, 8);
        check("sat_carry_hold", carry_total, 16'hFFFF);
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        evt_ready = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        check("sat_drained", fifo_level, 0);

        // Clear wins over a coincident carry; the record is still queued
        evt_ready = 1'b0;
        clear = 1'b1;
        drive(9'h1FE, 1'b1, 1'b0, 1'b0);
        tick();
        clear = 1'b0;
        check("clrc_carry", carry_total, 0);
        check("clrc_drop", drop_total, 0);
        check("clrc_ovf", overflow_sticky, 0);
        check("clrc_level", fifo_level, 1);
        check("clrc_flags", evt_flags, 3'b001);
        for (int k = 0; k < 3; k++) tick();
        check("pre_rst_level", fifo_level, 4);

        // Reset with 4 entries queued
        reset = 1'b1;
        drive(9'h000, 1'b0, 1'b0, 1'b0);
        tick();
        reset = 1'b0;
        check("mid_rst_valid", evt_valid, 0);
        check("mid_rst_level", fifo_level, 0);
        check("mid_rst_carry", carry_total, 0);
        check("mid_rst_time", evt_time, 0);
        drive(9'h001, 1'b1, 1'b0, 1'b0);
        tick();
        check("post_rst_time", evt_time, 0);
        check("post_rst_count", evt_count, 9'h001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
